// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared types and constants for the RV64M divider
//
// Purpose: operation and FSM state enumerations for riscv_core_divider,
//          word-op width, default XLEN and counter width, and decode helpers.
// Ports:   none (package).

package riscv_core_pkg;

  localparam int DIV_XLEN   = 64;
  localparam int DIV_W_BITS = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_XLEN);

  typedef enum logic [2:0] {
    OP_DIV   = 3'd0,
    OP_DIVU  = 3'd1,
    OP_REM   = 3'd2,
    OP_REMU  = 3'd3,
    OP_DIVW  = 3'd4,
    OP_DIVUW = 3'd5,
    OP_REMW  = 3'd6,
    OP_REMUW = 3'd7
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // The encoding groups the attributes into single bits:
  // bit 0 = unsigned, bit 1 = remainder, bit 2 = word op.
  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_word(input div_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/riscv_core_div_step.sv
// rtl/riscv_core_div_step.sv - one combinational restoring-division step
//
// Purpose: shifts the next dividend bit into the partial remainder and
//          subtracts the divisor when that does not go negative.
// Ports:
//   rem           in  W  partial remainder (always < divisor)
//   dividend_bit  in  1  next dividend bit, MSB first
//   divisor       in  W  divisor magnitude
//   rem_next      out W  updated partial remainder
//   q_bit         out 1  quotient bit produced by this step

module riscv_core_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [W:0] shifted;

  assign shifted  = {rem, dividend_bit};
  assign q_bit    = (shifted >= {1'b0, divisor});
  // After a successful subtract the value is below the divisor, so it fits W bits.
  assign rem_next = q_bit ? W'(shifted - {1'b0, divisor}) : {rem[W-2:0], dividend_bit};

endmodule

// File: rtl/riscv_core_divider.sv
// rtl/riscv_core_divider.sv - iterative radix-2 restoring divider for RV64M DIV/REM
//
// Purpose: one operation per handshake, one quotient bit per cycle, signed
//          fix-up, W-op sign extension, divide-by-zero and overflow results.
// Configuration macro: RISCV_CORE_DIV_FAST_SPECIAL_EN - divide-by-zero and
//          signed overflow skip the iteration and finish one cycle after accept.
// Ports:
//   i_clk               in  1     clock, rising edge
//   i_rst_n             in  1     asynchronous active-low reset
//   i_div_valid         in  1     request valid
//   o_div_ready         out 1     idle, request accepted this cycle
//   i_div_op            in  3     div_op_e
//   i_div_rs1           in  XLEN  dividend
//   i_div_rs2           in  XLEN  divisor
//   i_div_flush         in  1     abort in-flight operation
//   o_div_result_valid  out 1     result valid, held until acknowledged
//   i_div_result_ready  in  1     consumer accepts result
//   o_div_result        out XLEN  quotient or remainder

module riscv_core_divider
  import riscv_core_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [2:0]      i_div_op,
  input  logic [XLEN-1:0] i_div_rs1,
  input  logic [XLEN-1:0] i_div_rs2,
  input  logic            i_div_flush,
  output logic            o_div_result_valid,
  input  logic            i_div_result_ready,
  output logic [XLEN-1:0] o_div_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int HI_W  = XLEN - DIV_W_BITS;

  div_state_e state_q, state_d;

  logic [XLEN-1:0]  rem_q;     // partial remainder
  logic [XLEN-1:0]  dq_q;      // dividend shifts out the top, quotient shifts in the bottom
  logic [XLEN-1:0]  dv_q;      // divisor magnitude
  logic [XLEN-1:0]  a_raw_q;   // original dividend, for divide-by-zero remainder
  logic [CNT_W-1:0] cnt_q;
  logic             w_q, rem_sel_q, neg_q_q, neg_r_q, dz_q, ovf_q;
  logic [XLEN-1:0]  result_q;

  logic load, step_en, fix_en;

  // Request decode and operand preparation
  div_op_e          op_in;
  logic             in_w, in_signed, in_rem;
  logic [31:0]      a_lo, b_lo;
  logic             a_neg, b_neg;
  logic [31:0]      a_mag_w, b_mag_w;
  logic [XLEN-1:0]  a_mag_x, b_mag_x;
  logic [XLEN-1:0]  dq_init, dv_init;
  logic             dz_in, ovf_in, special_in;

  assign op_in     = div_op_e'(i_div_op);
  assign in_w      = op_is_word(op_in);
  assign in_signed = op_is_signed(op_in);
  assign in_rem    = op_is_rem(op_in);
  assign a_lo      = i_div_rs1[31:0];
  assign b_lo      = i_div_rs2[31:0];

  always_comb begin
    a_neg   = in_signed & (in_w ? a_lo[31] : i_div_rs1[XLEN-1]);
    b_neg   = in_signed & (in_w ? b_lo[31] : i_div_rs2[XLEN-1]);
    a_mag_w = a_neg ? -a_lo : a_lo;
    b_mag_w = b_neg ? -b_lo : b_lo;
    a_mag_x = a_neg ? -i_div_rs1 : i_div_rs1;
    b_mag_x = b_neg ? -i_div_rs2 : i_div_rs2;
    // Word dividends sit in the top half so the MSB-first shift needs only 32 steps.
    dq_init = in_w ? {a_mag_w, {HI_W{1'b0}}} : a_mag_x;
    dv_init = in_w ? {{HI_W{1'b0}}, b_mag_w} : b_mag_x;
    dz_in   = in_w ? (b_lo == '0) : (i_div_rs2 == '0);
    ovf_in  = in_signed & (in_w ? ((a_lo == 32'h8000_0000) && (&b_lo))
                                : ((i_div_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_div_rs2)));
    special_in = dz_in | ovf_in;
  end

  // Result for divide-by-zero (quotient -1, remainder dividend) and signed
  // overflow (quotient dividend, remainder 0), sign-extended for word ops.
  function automatic logic [XLEN-1:0] special_value(input logic w, input logic r,
                                                    input logic [XLEN-1:0] a, input logic dz);
    logic [XLEN-1:0] v;
    if (dz) v = r ? a : '1;
    else    v = r ? '0 : a;
    return w ? {{HI_W{v[31]}}, v[31:0]} : v;
  endfunction

  // Restoring step
  logic [XLEN-1:0] rem_nx;
  logic            q_bit;

  riscv_core_div_step #(.W(XLEN)) u_step (
    .rem          (rem_q),
    .dividend_bit (dq_q[XLEN-1]),
    .divisor      (dv_q),
    .rem_next     (rem_nx),
    .q_bit        (q_bit)
  );

  // Sign fix-up and result selection
  logic [XLEN-1:0] q_s, r_s, sel, fixed;

  always_comb begin
    q_s   = neg_q_q ? -dq_q : dq_q;
    r_s   = neg_r_q ? -rem_q : rem_q;
    sel   = rem_sel_q ? r_s : q_s;
    fixed = w_q ? {{HI_W{sel[31]}}, sel[31:0]} : sel;
    if (dz_q || ovf_q) fixed = special_value(w_q, rem_sel_q, a_raw_q, dz_q);
  end

  // FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_div_valid) begin
          load = 1'b1;
`ifdef RISCV_CORE_DIV_FAST_SPECIAL_EN
          state_d = special_in ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        fix_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (i_div_result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A pipeline kill beats any accept or acknowledge in the same cycle.
    if (i_div_flush) begin
      state_d = IDLE;
      load    = 1'b0;
      step_en = 1'b0;
      fix_en  = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q     <= '0;
      dq_q      <= '0;
      dv_q      <= '0;
      a_raw_q   <= '0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else if (i_div_flush) begin
      result_q <= '0;
    end else if (load) begin
      rem_q     <= '0;
      dq_q      <= dq_init;
      dv_q      <= dv_init;
      a_raw_q   <= i_div_rs1;
      cnt_q     <= in_w ? CNT_W'(DIV_W_BITS - 1) : CNT_W'(XLEN - 1);
      w_q       <= in_w;
      rem_sel_q <= in_rem;
      neg_q_q   <= a_neg ^ b_neg;
      neg_r_q   <= a_neg;
      dz_q      <= dz_in;
      ovf_q     <= ovf_in;
`ifdef RISCV_CORE_DIV_FAST_SPECIAL_EN
      if (special_in) result_q <= special_value(in_w, in_rem, i_div_rs1, dz_in);
`endif
    end else if (step_en) begin
      rem_q <= rem_nx;
      dq_q  <= {dq_q[XLEN-2:0], q_bit};
      cnt_q <= cnt_q - 1'b1;
    end else if (fix_en) begin
      result_q <= fixed;
    end
  end

  assign o_div_ready        = (state_q == IDLE);
  assign o_div_result_valid = (state_q == DONE);
  assign o_div_result       = result_q;

endmodule

// File: tb/tb_riscv_core_divider.sv
// tb/tb_riscv_core_divider.sv - scoreboard testbench for riscv_core_divider

module tb_riscv_core_divider;

  localparam logic [2:0] DIV = 3'd0, DIVU = 3'd1, REM = 3'd2, REMU = 3'd3,
                         DIVW = 3'd4, DIVUW = 3'd5, REMW = 3'd6, REMUW = 3'd7;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_div_valid = 1'b0;
  logic        o_div_ready;
  logic [2:0]  i_div_op = 3'd0;
  logic [63:0] i_div_rs1 = '0;
  logic [63:0] i_div_rs2 = '0;
  logic        i_div_flush = 1'b0;
  logic        o_div_result_valid;
  logic        i_div_result_ready = 1'b0;
  logic [63:0] o_div_result;

  riscv_core_divider dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_div_valid        (i_div_valid),
    .o_div_ready        (o_div_ready),
    .i_div_op           (i_div_op),
    .i_div_rs1          (i_div_rs1),
    .i_div_rs2          (i_div_rs2),
    .i_div_flush        (i_div_flush),
    .o_div_result_valid (o_div_result_valid),
    .i_div_result_ready (i_div_result_ready),
    .o_div_result       (o_div_result)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit hold_ready = 1'b0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural RV64M results.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    longint      sa, sb_;
    int          sa32, sb32;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0]; b32 = b[31:0];
    sa = a; sb_ = b; sa32 = a32; sb32 = b32;
    r64 = '0; r32 = '0;
    case (op)
      DIV:   r64 = (b == 0) ? '1 : (a == MIN64 && b == '1) ? a : 64'(sa / sb_);
      DIVU:  r64 = (b == 0) ? '1 : a / b;
      REM:   r64 = (b == 0) ? a  : (a == MIN64 && b == '1) ? 64'd0 : 64'(sa % sb_);
      REMU:  r64 = (b == 0) ? a  : a % b;
      DIVW:  r32 = (b32 == 0) ? '1 : (a32 == 32'h8000_0000 && b32 == '1) ? a32 : 32'(sa32 / sb32);
      DIVUW: r32 = (b32 == 0) ? '1 : a32 / b32;
      REMW:  r32 = (b32 == 0) ? a32 : (a32 == 32'h8000_0000 && b32 == '1) ? 32'd0 : 32'(sa32 % sb32);
      default: r32 = (b32 == 0) ? a32 : a32 % b32;
    endcase
    return op[2] ? {{32{r32[31]}}, r32} : r64;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    bit sgn, special;
    int lat;
    sgn = (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
    if (op[2]) special = (b[31:0] == 0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
    else       special = (b == 0) || (sgn && a == MIN64 && b == '1);
    lat = op[2] ? 34 : 66;
`ifdef RISCV_CORE_DIV_FAST_SPECIAL_EN
    if (special) lat = 1;
`else
    if (special) lat = lat + 0;
`endif
    return lat;
  endfunction

  // Drive a request; the expectation is queued at the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input string name);
    exp_t e;
    @(posedge i_clk); #1;
    i_div_valid = 1'b1; i_div_op = op; i_div_rs1 = a; i_div_rs2 = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_div_ready) begin
        e.res = ref_model(op, a, b); e.lat = ref_latency(op, a, b);
        e.acc = cyc; e.name = name;
        sb.push_back(e);
        @(posedge i_clk); #1;
        i_div_valid = 1'b0;
        return;
      end
    end
    i_div_valid = 1'b0;
    check({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge i_clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return {$urandom, $urandom};
      1: return 64'd0;
      2: return MIN64;
      3: return '1;
      4: return 64'($urandom_range(1, 20));
      5: return {32'h0, 32'h8000_0000};
      default: return {32'h0, $urandom};
    endcase
  endfunction

  // Consumer: random backpressure unless held off.
  initial begin
    forever begin
      @(posedge i_clk); #1;
      i_div_result_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          seen;
    logic [63:0] held;
    exp_t        e;
    seen = 1'b0; held = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_div_result_valid) begin
        check("ready_low_while_valid", 64'(o_div_ready), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_result", o_div_result, 64'hx);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            held = o_div_result;
            check({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          end else begin
            check({sb[0].name, "_stable"}, o_div_result, held);
          end
          if (i_div_result_ready) begin
            e = sb.pop_front();
            check(e.name, o_div_result, e.res);
            seen = 1'b0;
          end
        end
      end
      if (!i_rst_n) seen = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_ready", 64'(o_div_ready), 64'd1);
    check("reset_valid", 64'(o_div_result_valid), 64'd0);
    check("reset_result", o_div_result, 64'd0);
    @(negedge i_clk); i_rst_n = 1'b1;

    issue(DIVU, 64'd100, 64'd7, "divu_100_7");
    issue(REMU, 64'd100, 64'd7, "remu_100_7");
    issue(DIV, -64'sd100, 64'd7, "div_m100_7");
    issue(REM, -64'sd100, 64'd7, "rem_m100_7");
    issue(REM, 64'd100, -64'sd7, "rem_100_m7");
    issue(DIVU, 64'd5, 64'd0, "divu_by_zero");
    issue(REMU, 64'd5, 64'd0, "remu_by_zero");
    issue(DIVW, 64'd5, 64'h1_0000_0000, "divw_by_zero");
    issue(DIV, MIN64, '1, "div_overflow");
    issue(REM, MIN64, '1, "rem_overflow");
    issue(DIVW, 64'h8000_0000, '1, "divw_overflow");
    drain();

    // Backpressure: result must hold while ready is low.
    hold_ready = 1'b1;
    issue(DIVUW, 64'hFFFF_FFFF, 64'd1, "divuw_hold");
    for (int i = 0; i < 100 && !o_div_result_valid; i++) @(posedge i_clk);
    repeat (5) @(posedge i_clk);
    hold_ready = 1'b0;
    drain();

    // Flush mid-CALC: nothing queued, so any result would be flagged.
    @(posedge i_clk); #1;
    i_div_valid = 1'b1; i_div_op = DIVU; i_div_rs1 = 64'd1000; i_div_rs2 = 64'd3;
    @(posedge i_clk); #1;
    i_div_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1 i_div_flush = 1'b1;
    @(posedge i_clk); #1;
    i_div_flush = 1'b0;
    @(negedge i_clk);
    check("flush_valid", 64'(o_div_result_valid), 64'd0);
    check("flush_ready", 64'(o_div_ready), 64'd1);
    repeat (80) @(posedge i_clk);

    // Reset mid-CALC, with a nonzero previous result in the output register.
    issue(DIVU, 64'd100, 64'd7, "divu_pre_reset");
    drain();
    @(posedge i_clk); #1;
    i_div_valid = 1'b1; i_div_op = DIV; i_div_rs1 = 64'd77; i_div_rs2 = 64'd5;
    @(posedge i_clk); #1;
    i_div_valid = 1'b0;
    repeat (20) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midreset_ready", 64'(o_div_ready), 64'd1);
    check("midreset_valid", 64'(o_div_result_valid), 64'd0);
    check("midreset_result", o_div_result, 64'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    issue(DIVU, 64'd9, 64'd3, "divu_9_3");
    drain();

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [63:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(op, a, b, $sformatf("rand%0d_op%0d", n, op));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
